instr_fetch_queue: RTL and testbench

Instruction fetch stage placed directly upstream of the single-cycle datapath's decode (control, alu_decoder, regfile). It owns the program counter, issues in-order word requests to an instruction memory with variable latency, buffers returned words with their PCs in a small FIFO, and presents them to the core through a valid/ready handshake. A redirect input (taken branch, jump) flushes buffered and in-flight instructions and restarts fetch at a new address.

---
 rtl/instr_fetch_queue_if.sv | 30 +++
 rtl/instr_fetch_queue.sv | 86 ++++++++
 tb/tb_instr_fetch_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the core-side
// valid/ready instruction stream and redirect. The master modport is the fetch unit.
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [31:0]     if_pc;
  logic            if_ready;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic [LvlW-1:0] fill_level;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fill_level,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fill_level,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues in-order word requests, buffers returned
// words with their PCs and discards responses that belong to a flushed fetch stream.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  instr_fetch_queue_if.master    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_count;
  logic [LW-1:0] r_outst;
  logic [LW-1:0] r_drop;

  logic          w_req;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [LW:0]   w_credit;
  logic [31:0]   w_redir_pc;

  // Outstanding words include those already marked for dropping, so credit stays exact.
  assign w_credit   = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req      = i_rst_n && !bus.redirect && (w_credit < (LW + 1)'(DEPTH));
  assign w_grant    = w_req && bus.imem_gnt;
  assign w_rsp      = bus.imem_rvalid && (r_outst != '0);
  assign w_push     = w_rsp && (r_drop == '0) && !bus.redirect;
  assign w_pop      = (r_count != '0) && bus.if_ready && !bus.redirect;
  assign w_redir_pc = bus.redirect_pc & ~32'h3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (bus.redirect) begin
      // Everything still in flight, minus a response landing now, belongs to the old stream.
      r_fetch_pc <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_outst    <= r_outst - LW'(w_rsp);
      r_drop     <= r_outst - LW'(w_rsp);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outst <= r_outst + LW'(w_grant) - LW'(w_rsp);
      if (w_rsp && (r_drop != '0)) r_drop <= r_drop - LW'(1);
      if (w_push) begin
        r_wptr    <= r_wptr + AW'(1);
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= r_resp_pc;
      r_instr_mem[r_wptr] <= bus.imem_rdata;
    end
  end

  // Head outputs read as zero while empty so reset and flush present a clean bus.
  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.if_valid   = (r_count != '0);
  assign bus.if_instr   = (r_count != '0) ? r_instr_mem[r_rptr] : 32'h0;
  assign bus.if_pc      = (r_count != '0) ? r_pc_mem[r_rptr] : 32'h0;
  assign bus.fill_level = r_count;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a variable-latency memory model tags each grant
// with the fetch epoch; only current-epoch responses are expected at the core side.
module tb_instr_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          lat     = 1;
  logic        stray   = 1'b0;
  int          epoch   = 0;
  int          rsp_ep  = -1;
  logic [31:0] rsp_addr;
  logic [31:0] exp_pc  = RESET_PC;
  int          pops    = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          pend_ep[$];
  logic [31:0] sb_pc[$];
  logic [31:0] sb_instr[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    rsp_ep = -1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_BAD0;
    end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      rsp_addr = pend_addr.pop_front();
      rsp_ep   = pend_ep.pop_front();
      void'(pend_due.pop_front());
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word(rsp_addr);
    end
  endtask

  // Observe one cycle on the falling edge, then advance to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.redirect) check_eq("req_in_redirect", 32'(bus.imem_req), 32'd0);
    if (bus.if_valid && bus.if_ready && !bus.redirect) begin
      check_eq("sb_has_entry", 32'(sb_pc.size() != 0), 32'd1);
      check_eq("pop_pc_seq", bus.if_pc, exp_pc);
      check_eq("pop_instr", bus.if_instr, word(exp_pc));
      exp_pc += 32'd4;
      if (sb_pc.size() != 0) begin
        check_eq("sb_pc", bus.if_pc, sb_pc.pop_front());
        check_eq("sb_instr", bus.if_instr, sb_instr.pop_front());
      end
      pops++;
    end
    if (bus.imem_rvalid && rsp_ep == epoch && !bus.redirect) begin
      sb_pc.push_back(rsp_addr);
      sb_instr.push_back(word(rsp_addr));
    end
    if (bus.imem_req && bus.imem_gnt) begin
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(cyc + lat);
      pend_ep.push_back(epoch);
    end
    if (bus.redirect) begin
      epoch++;
      sb_pc.delete();
      sb_instr.delete();
      exp_pc = bus.redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check_eq({tag, "_addr"},  bus.imem_addr, RESET_PC);
    check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
    check_eq({tag, "_instr"}, bus.if_instr, 32'd0);
    check_eq({tag, "_pc"},    bus.if_pc, 32'd0);
    check_eq({tag, "_fill"},  32'(bus.fill_level), 32'd0);
  endtask

  task automatic reset_model();
    pend_addr.delete();
    pend_due.delete();
    pend_ep.delete();
    sb_pc.delete();
    sb_instr.delete();
    epoch++;
    exp_pc = RESET_PC;
  endtask

  initial begin
    int p0;
    rst_n           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.if_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("first_req", 32'(bus.imem_req), 32'd1);
    check_eq("first_addr", bus.imem_addr, RESET_PC);

    // Stream: latency 1, full grant, core always ready -> one instruction per cycle.
    lat = 1;
    bus.imem_gnt = 1'b1;
    bus.if_ready = 1'b1;
    ticks(4);
    p0 = pops;
    ticks(16);
    check_eq("stream_rate", 32'(pops - p0), 32'd16);

    // Backpressure: queue fills to DEPTH and requests stop.
    bus.if_ready = 1'b0;
    ticks(10);
    check_eq("bp_fill", 32'(bus.fill_level), DEPTH);
    check_eq("bp_req", 32'(bus.imem_req), 32'd0);
    bus.if_ready = 1'b1;
    p0 = pops;
    ticks(10);
    check_eq("bp_release", 32'(pops - p0 >= 5), 32'd1);

    // Redirect with several words in flight at latency 3; low bits of target ignored.
    lat = 3;
    ticks(8);
    do_redirect(32'h0000_0103);
    p0 = pops;
    for (int i = 0; i < 40 && pops < p0 + 3; i++) tick();
    check_eq("redir_progress", 32'(pops >= p0 + 3), 32'd1);

    // Redirect coincident with an arriving response and a pop.
    lat = 1;
    ticks(6);
    check_eq("coinc_valid_pre", 32'(bus.if_valid), 32'd1);
    do_redirect(32'h0000_0300);
    check_eq("coinc_fill", 32'(bus.fill_level), 32'd0);
    check_eq("coinc_valid", 32'(bus.if_valid), 32'd0);
    ticks(6);

    // PC wrap with best-case redirect-to-instruction latency.
    do_redirect(32'hFFFF_FFFC);
    ticks(2);
    check_eq("wrap_valid", 32'(bus.if_valid), 32'd1);
    check_eq("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    p0 = pops;
    ticks(4);
    check_eq("wrap_progress", 32'(pops - p0 >= 2), 32'd1);

    // Mid-operation reset with two words outstanding, then a stray response.
    lat = 3;
    do_redirect(32'h0000_0200);
    bus.imem_gnt = 1'b1;
    ticks(2);
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    reset_model();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_req", 32'(bus.imem_req), 32'd1);
    check_eq("midrst_addr", bus.imem_addr, RESET_PC);
    stray = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick();
    stray = 1'b0;
    bus.imem_rvalid = 1'b0;
    check_eq("stray_fill", 32'(bus.fill_level), 32'd0);
    check_eq("stray_valid", 32'(bus.if_valid), 32'd0);
    lat = 1;
    bus.imem_gnt = 1'b1;
    p0 = pops;
    ticks(8);
    check_eq("restart_progress", 32'(pops - p0 >= 4), 32'd1);

    // Drain: stop granting and let everything reach the core.
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 20 && (bus.fill_level != 0 || pend_due.size() != 0); i++) tick();
    ticks(2);
    check_eq("drain_fill", 32'(bus.fill_level), 32'd0);
    check_eq("drain_sb_empty", 32'(sb_pc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
